control_sequencer: RTL

- Fetch/decode/execute sequencer for the 4-bit core.
- Holds the 4-bit program counter and the 8-bit instruction register.
- Drives the 16-bit control word consumed by the operand-select mux, register file, ALU, accumulator and output latch.
- Sits directly upstream of the operand mux. Bits 3, 4 and 7 are that mux's select lines for Register A, Register B and ACC-NZ-A respectively.

---
 rtl/control_sequencer_if.sv | 26 ++
 rtl/control_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Groups the sequencer's run/program-memory/flag inputs and its pc/imm/control/halted outputs.
// Pure wiring, no latency.
// No backpressure: every signal is a level, sampled or driven each cycle.
interface control_sequencer_if #(
  parameter int PC_W = 4
);
  logic            run;
  logic [7:0]      instr;
  logic            zero_flag;
  logic [PC_W-1:0] pc;
  logic [3:0]      imm;
  logic [15:0]     control;
  logic            halted;

  // sequencer side
  modport master (
    input  run, instr, zero_flag,
    output pc, imm, control, halted
  );

  // program memory / datapath side
  modport slave (
    output run, instr, zero_flag,
    input  pc, imm, control, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: holds pc and IR, decodes the 16-bit control word.
// Three cycles per instruction (FETCH, DECODE, EXECUTE); control/halted are combinational from state, IR, zero_flag.
// No backpressure: run is sampled only in IDLE and at the end of EXECUTE; HALT is left only via rst.
module control_sequencer #(
  parameter int         PC_W     = 4,
  parameter logic [3:0] HALT_OPC = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  control_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // control word bit positions
  localparam int PC_INC   = 0;
  localparam int IR_LOAD  = 1;
  localparam int A_LOAD   = 2;
  localparam int SEL_A    = 3;
  localparam int SEL_B    = 4;
  localparam int ACC_LOAD = 5;
  localparam int ACC_CLR  = 6;
  localparam int SEL_A_NZ = 7;
  localparam int ALU_ADD  = 8;
  localparam int ALU_SUB  = 9;
  localparam int OUT_LOAD = 10;
  localparam int JUMP     = 11;
  localparam int B_LOAD   = 12;
  localparam int IMM_SEL  = 13;
  localparam int HALT     = 14;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q;
  logic            ir_ld, pc_ld, taken;
  logic [15:0]     ctrl;
  logic [3:0]      opc;

  assign opc = ir_q[7:4];

  // state, pc and IR registers; reset discards any pending pc update
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc_q  <= '0;
      ir_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (ir_ld) ir_q <= bus.instr;
      if (pc_ld) pc_q <= pc_d;
    end
  end

  // next-state, pc update and control word decode
  always_comb begin
    state_nxt = state;
    ctrl      = 16'h0000;
    ir_ld     = 1'b0;
    pc_ld     = 1'b0;
    pc_d      = pc_q;
    taken     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        ctrl[IR_LOAD] = 1'b1;
        ir_ld         = 1'b1;
        state_nxt     = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = (opc == HALT_OPC) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (opc)
          4'h1: begin ctrl[A_LOAD] = 1'b1; ctrl[IMM_SEL] = 1'b1; end
          4'h2: begin ctrl[B_LOAD] = 1'b1; ctrl[IMM_SEL] = 1'b1; end
          4'h3: begin ctrl[SEL_A] = 1'b1; ctrl[ALU_ADD] = 1'b1; ctrl[ACC_LOAD] = 1'b1; end
          4'h4: begin ctrl[SEL_B] = 1'b1; ctrl[ALU_ADD] = 1'b1; ctrl[ACC_LOAD] = 1'b1; end
          4'h5: begin ctrl[SEL_A] = 1'b1; ctrl[ALU_SUB] = 1'b1; ctrl[ACC_LOAD] = 1'b1; end
          4'h6: begin ctrl[SEL_B] = 1'b1; ctrl[ALU_SUB] = 1'b1; ctrl[ACC_LOAD] = 1'b1; end
          4'h7: begin
            if (!bus.zero_flag) begin
              ctrl[SEL_A_NZ] = 1'b1;
              ctrl[ALU_ADD]  = 1'b1;
              ctrl[ACC_LOAD] = 1'b1;
            end
          end
          4'h8: ctrl[ACC_CLR]  = 1'b1;
          4'h9: ctrl[OUT_LOAD] = 1'b1;
          4'hA: taken = 1'b1;
          4'hB: taken = bus.zero_flag;
          default: ;
        endcase
        pc_ld = 1'b1;
        if (taken) begin
          ctrl[JUMP] = 1'b1;
          pc_d       = PC_W'(ir_q[3:0]);
        end else begin
          ctrl[PC_INC] = 1'b1;
          pc_d         = pc_q + PC_W'(1);
        end
        state_nxt = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        ctrl[HALT] = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.imm     = ir_q[3:0];
  assign bus.control = ctrl;
  assign bus.halted  = (state == S_HALT);

endmodule
